// File: rtl/mips_pkg.sv
// Shared definitions for the mips instruction fetch front-end: word geometry,
// PC alignment and the fetch FSM state encoding.
package mips_pkg;

    localparam int WORD_SIZE_DEF = 32;
    localparam int INSTR_BYTES   = 4;

    // Instruction addresses are word aligned; the low bits are always cleared.
    localparam logic [WORD_SIZE_DEF-1:0] PC_ALIGN_MASK = ~WORD_SIZE_DEF'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Small prefetch FIFO holding {pc, instruction} pairs; head is presented
// combinationally and reads as zero while empty. Flush empties it in one cycle.
module mips_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    input  logic                    flush,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign count   = count_reg;
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch front-end: single-outstanding imem requests, prefetch FIFO,
// redirect with flush. Optional MIPS_FETCH_BYPASS_EN gives a zero-latency empty-FIFO path.
module mips_fetch
    import mips_pkg::*;
#(
    parameter int                   WORD_SIZE  = WORD_SIZE_DEF,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 inst_valid,
    output logic [WORD_SIZE-1:0] inst_data,
    output logic [WORD_SIZE-1:0] inst_pc,
    input  logic                 inst_ready
);

    localparam int                   CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int                   DW         = 2 * WORD_SIZE;
    localparam logic [CW-1:0]        DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(~PC_ALIGN_MASK);
    localparam logic [WORD_SIZE-1:0] STEP       = WORD_SIZE'(INSTR_BYTES);

    fetch_state_t         state_reg, state_next;
    logic [WORD_SIZE-1:0] addr_reg, addr_next;
    logic [WORD_SIZE-1:0] redir_reg, redir_next;
    logic [WORD_SIZE-1:0] rpc;
    logic                 ack_keep;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DW-1:0]        fifo_rdata;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_after;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign imem_req  = (state_reg != IDLE);
    assign imem_addr = addr_reg;
    assign rpc       = redirect_pc & ALIGN_MASK;
    assign ack_keep  = (state_reg == REQ) & imem_ack & ~redirect_valid;

`ifdef MIPS_FETCH_BYPASS_EN
    logic bypass;
    // Empty FIFO: hand the acked word straight to decode and skip the FIFO if taken.
    assign bypass     = ack_keep & fifo_empty;
    assign inst_valid = ~fifo_empty | bypass;
    assign inst_pc    = bypass ? addr_reg   : fifo_rdata[DW-1:WORD_SIZE];
    assign inst_data  = bypass ? imem_rdata : fifo_rdata[WORD_SIZE-1:0];
    assign fifo_push  = ack_keep & ~(bypass & inst_ready);
`else
    assign inst_valid = ~fifo_empty;
    assign inst_pc    = fifo_rdata[DW-1:WORD_SIZE];
    assign inst_data  = fifo_rdata[WORD_SIZE-1:0];
    assign fifo_push  = ack_keep;
`endif

    assign fifo_pop    = inst_valid & inst_ready & ~fifo_empty;
    assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    mips_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({addr_reg, imem_rdata}),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            addr_reg  <= RESET_PC;
            redir_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            redir_reg <= redir_next;
        end
    end

    // addr_reg always holds the address of the current or next request, so it
    // stays stable while a request is outstanding; a redirect during one parks in redir_reg.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        redir_next = redir_reg;
        unique case (state_reg)
            IDLE: begin
                if (redirect_valid) begin
                    addr_next  = rpc;
                    state_next = REQ;
                end else if (!fifo_full) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        addr_next = rpc;
                    end else begin
                        redir_next = rpc;
                        state_next = DROP;
                    end
                end else if (imem_ack) begin
                    addr_next  = addr_reg + STEP;
                    state_next = (count_after < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    addr_next  = redirect_valid ? rpc : redir_reg;
                    state_next = REQ;
                end else if (redirect_valid) begin
                    redir_next = rpc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_fetch.sv
// Scoreboard bench for mips_fetch: directed scenarios push expected {pc, data}
// words; an independent monitor pops and compares on every decode handshake.
`timescale 1ns/1ps
module tb_mips_fetch;

    localparam logic [31:0] K = 32'hA5A5_0000;
`ifdef MIPS_FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_data, inst_pc;

    logic        w_req, w_ack = 1'b0, w_valid;
    logic [31:0] w_addr, w_rdata = '0, w_data, w_pc;
    logic        w_ready = 1'b1;
    logic        w_redir = 1'b0;
    logic [31:0] w_redir_pc = '0;

    exp_t        exp_q[$];
    logic [31:0] ack_log[$];
    logic [31:0] w_log[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          mem_delay = 1;
    int          wait_cnt = 0;
    int          acks_left = 0;

    always #5 clk = ~clk;

    mips_fetch u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    mips_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .inst_valid(w_valid), .inst_data(w_data), .inst_pc(w_pc),
        .inst_ready(w_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock of the memory models; all bench inputs change at the falling edge.
    task automatic tick();
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        if (rst && imem_req) begin
            if (acks_left > 0 && wait_cnt >= mem_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ K;
                ack_log.push_back(imem_addr);
                acks_left--;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        w_ack = 1'b0;
        if (rst && w_req) begin
            w_ack   = 1'b1;
            w_rdata = w_addr ^ K;
            if (w_log.size() < 3) w_log.push_back(w_addr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        ack_log.delete();
        w_log.delete();
        wait_cnt = 0;
        acks_left = 0;
        rst = 1'b1;
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = pc ^ K;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] req);
        if (idx < ack_log.size()) begin
            check(name, ack_log[idx], req);
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no request at index %0d, required %h", name, idx, req);
        end
    endtask

    // Monitor: samples just before the rising edge, when inputs and outputs are settled.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #4;
        if (rst) begin
            if (inst_valid && inst_ready) begin
                $display("deliver pc=%h data=%h", inst_pc, inst_data);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got pc=%h data=%h, required none", inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_pc", inst_pc, e.pc);
                    check("deliver_data", inst_data, e.data);
                end
            end
            if (w_valid) check("wrap_data", w_data, w_pc ^ K);
        end
    end

    initial begin
        int n;
        #1 rst = 1'b0;
        repeat (3) tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_data", inst_data, 32'h0);
        check("rst_pc", inst_pc, 32'h0);

        // Sequential fetch, eight words, decode always ready
        inst_ready = 1'b1;
        mem_delay  = 1;
        acks_left  = 8;
        for (int i = 0; i < 8; i++) expect_word(32'(i * 4));
        w_log.delete();
        rst = 1'b1;
        n = 0;
        while (!imem_ack && n < 20) begin
            tick();
            n++;
        end
        check("seq_first_ack", {31'd0, imem_ack}, 32'd1);
        #1 check("seq_ack_cycle_valid", {31'd0, inst_valid}, {31'd0, BYP});
        tick();
        #1 check("seq_next_cycle_valid", {31'd0, inst_valid}, {31'd0, ~BYP});
        wait_drain("seq");
        check("seq_acks", ack_log.size(), 32'd8);
        for (int i = 0; i < 8; i++) check_log($sformatf("seq_addr%0d", i), i, 32'(i * 4));
        check("seq_pending_addr", imem_addr, 32'h20);

        // PC wrap on the second instance
        check("wrap_count", w_log.size(), 32'd3);
        if (w_log.size() == 3) begin
            check("wrap_addr0", w_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", w_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", w_log[2], 32'h0000_0000);
        end

        // Backpressure: four credits then stall
        do_reset();
        inst_ready = 1'b0;
        acks_left  = 100;
        repeat (20) tick();
        check("bp_acks", ack_log.size(), 32'd4);
        check("bp_req_idle", {31'd0, imem_req}, 32'd0);
        check("bp_head_valid", {31'd0, inst_valid}, 32'd1);
        check("bp_head_pc", inst_pc, 32'h0);
        check("bp_head_data", inst_data, K);
        acks_left = 2;
        for (int i = 0; i < 6; i++) expect_word(32'(i * 4));
        inst_ready = 1'b1;
        wait_drain("bp");
        check("bp_acks_total", ack_log.size(), 32'd6);
        check_log("bp_resume_addr", 4, 32'h10);

        // Redirect while a request is outstanding
        do_reset();
        acks_left = 2;
        expect_word(32'h0);
        expect_word(32'h4);
        wait_drain("rd_pre");
        check("rd_pending_addr", imem_addr, 32'h8);
        check("rd_pending_req", {31'd0, imem_req}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        #1 check("rd_drop_addr_stable", imem_addr, 32'h8);
        check("rd_drop_req", {31'd0, imem_req}, 32'd1);
        check("rd_valid_low", {31'd0, inst_valid}, 32'd0);
        expect_word(32'h100);
        expect_word(32'h104);
        acks_left = 3;
        wait_drain("rd");
        check_log("rd_dropped_addr", 2, 32'h8);
        check_log("rd_restart_addr", 3, 32'h100);
        check_log("rd_next_addr", 4, 32'h104);

        // Redirect coincident with an ack
        do_reset();
        acks_left = 3;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        wait_drain("rc_pre");
        acks_left = 1;
        tick();
        check("rc_acked_addr", imem_addr, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        #1 check("rc_valid_low", {31'd0, inst_valid}, 32'd0);
        check("rc_new_addr", imem_addr, 32'h40);
        check("rc_req", {31'd0, imem_req}, 32'd1);
        expect_word(32'h40);
        acks_left = 1;
        wait_drain("rc");

        // Asynchronous reset with a request outstanding
        do_reset();
        inst_ready = 1'b0;
        acks_left  = 2;
        repeat (10) tick();
        check("ar_pre_valid", {31'd0, inst_valid}, 32'd1);
        check("ar_pre_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b0;
        #1 check("ar_req", {31'd0, imem_req}, 32'd0);
        check("ar_valid", {31'd0, inst_valid}, 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_pc", inst_pc, 32'h0);
        tick();
        exp_q.delete();
        ack_log.delete();
        wait_cnt   = 0;
        rst        = 1'b1;
        inst_ready = 1'b1;
        acks_left  = 1;
        expect_word(32'h0);
        wait_drain("ar");
        check_log("ar_restart_addr", 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
